// File: rtl/reg_alu_pkg.sv
// reg_alu_pkg: shared definitions for the register-file ALU core.
// Holds instruction field positions, opcode/funct codes, the control
// state enum and a field-extraction helper.
package reg_alu_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned OP_W    = 6;
   localparam int unsigned FN_W    = 6;
   localparam int unsigned REG_FW  = 5;
   localparam int unsigned SH_W    = 5;
   localparam int unsigned IMM_W   = 16;

   // Field slice positions (lsb of each field)
   localparam int unsigned OP_LSB  = 26;
   localparam int unsigned RS_LSB  = 21;
   localparam int unsigned RT_LSB  = 16;
   localparam int unsigned RD_LSB  = 11;
   localparam int unsigned SH_LSB  = 6;
   localparam int unsigned FN_LSB  = 0;
   localparam int unsigned IMM_LSB = 0;

   // Opcodes
   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
   localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
   localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
   localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;

   // R-type funct codes
   localparam logic [FN_W-1:0] F_SLL  = 6'b000000;
   localparam logic [FN_W-1:0] F_SRL  = 6'b000010;
   localparam logic [FN_W-1:0] F_MUL  = 6'b011000;
   localparam logic [FN_W-1:0] F_ADD  = 6'b100000;
   localparam logic [FN_W-1:0] F_ADDU = 6'b100001;
   localparam logic [FN_W-1:0] F_SUB  = 6'b100010;
   localparam logic [FN_W-1:0] F_SUBU = 6'b100011;
   localparam logic [FN_W-1:0] F_AND  = 6'b100100;
   localparam logic [FN_W-1:0] F_OR   = 6'b100101;
   localparam logic [FN_W-1:0] F_SLT  = 6'b101010;
   localparam logic [FN_W-1:0] F_SLTU = 6'b101011;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } state_e;

   // Extract a 5-bit register/shamt field starting at lsb
   function automatic logic [REG_FW-1:0] reg_field(input logic [INSTR_W-1:0] instr,
                                                   input int unsigned lsb);
      return instr[lsb +: REG_FW];
   endfunction

endpackage

// File: rtl/reg_alu_if.sv
// reg_alu_if: instruction/result/debug bus of the register-file ALU core.
//   master (sequencer side): drives in_valid, instr, dbg_addr
//   slave  (core side):      drives in_ready, res_*, dbg_data
interface reg_alu_if #(
   parameter int unsigned XLEN = 32
);
   import reg_alu_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic [INSTR_W-1:0] instr;
   logic               res_valid;
   logic [XLEN-1:0]    res_data;
   logic [REG_FW-1:0]  res_dst;
   logic               res_err;
   logic [REG_FW-1:0]  dbg_addr;
   logic [XLEN-1:0]    dbg_data;

   modport master (
      output in_valid, instr, dbg_addr,
      input  in_ready, res_valid, res_data, res_dst, res_err, dbg_data
   );

   modport slave (
      input  in_valid, instr, dbg_addr,
      output in_ready, res_valid, res_data, res_dst, res_err, dbg_data
   );

endinterface

// File: rtl/reg_alu_mul.sv
// reg_alu_mul: iterative shift-add multiplier, one multiplier bit per cycle.
//   clk, rst : clock, synchronous active-high reset
//   start    : load a/b, clear accumulator, arm XLEN-step counter
//   a, b     : multiplicand, multiplier (sampled on start)
//   done     : high in the cycle whose edge retires the last step
//   product  : low XLEN bits of a*b, valid while done is high
// done/product are combinational so the owner can commit the result on the
// same edge that performs the final step.
module reg_alu_mul #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            done,
   output logic [XLEN-1:0] product
);

   localparam int unsigned CW = $clog2(XLEN + 1);

   logic [XLEN-1:0] mcand_q;
   logic [XLEN-1:0] mplier_q;
   logic [XLEN-1:0] acc_q;
   logic [CW-1:0]   cnt_q;
   logic [XLEN-1:0] partial;

   // Accumulator plus the current partial product
   assign partial = acc_q + (mplier_q[0] ? mcand_q : '0);

   // Operand/accumulator registers and step counter
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else if (start) begin
         mcand_q  <= a;
         mplier_q <= b;
         acc_q    <= '0;
         cnt_q    <= CW'(XLEN);
      end else if (cnt_q != '0) begin
         acc_q    <= partial;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q - CW'(1);
      end
   end

   assign done    = (cnt_q == CW'(1));
   assign product = partial;

endmodule

// File: rtl/reg_alu_core.sv
// reg_alu_core: MIPS-format R/I instruction executor with NREGS x XLEN
// register file, iterative multiply, illegal-op reporting and debug read.
//   clk, rst : clock, synchronous active-high reset
//   bus      : reg_alu_if slave (in_valid/in_ready/instr handshake,
//              res_valid/res_data/res_dst/res_err pulse, dbg_addr/dbg_data)
module reg_alu_core
   import reg_alu_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32
) (
   input  logic       clk,
   input  logic       rst,
   reg_alu_if.slave   bus
);

   localparam int unsigned AW  = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam int unsigned SHW = $clog2(XLEN);

   state_e state_q, state_d;

   logic [XLEN-1:0] regs [NREGS];

   logic [OP_W-1:0]  op;
   logic [FN_W-1:0]  fn;
   logic [SH_W-1:0]  shamt;
   logic [IMM_W-1:0] imm;
   logic [AW-1:0]    rs_i, rt_i, rd_i, dbg_i;
   logic [XLEN-1:0]  rs_v, rt_v, sext_imm, zext_imm;
   logic [SHW-1:0]   sh_amt;

   logic [XLEN-1:0]  alu_v;
   logic [AW-1:0]    alu_dst;
   logic             illegal, is_mul;

   logic             mul_start, mul_done;
   logic [XLEN-1:0]  mul_product;
   logic [AW-1:0]    mul_dst_q;

   logic             res_fire, res_err_d, wr_en;
   logic [XLEN-1:0]  res_data_d;
   logic [AW-1:0]    wr_idx;

   // Field decode; register indices use the low AW bits of each field
   assign op       = bus.instr[OP_LSB +: OP_W];
   assign fn       = bus.instr[FN_LSB +: FN_W];
   assign shamt    = reg_field(bus.instr, SH_LSB);
   assign imm      = bus.instr[IMM_LSB +: IMM_W];
   assign rs_i     = AW'(reg_field(bus.instr, RS_LSB));
   assign rt_i     = AW'(reg_field(bus.instr, RT_LSB));
   assign rd_i     = AW'(reg_field(bus.instr, RD_LSB));
   assign dbg_i    = AW'(bus.dbg_addr);
   assign sext_imm = XLEN'($signed(imm));
   assign zext_imm = XLEN'(imm);
   assign sh_amt   = SHW'(32'(shamt) % XLEN);

   // Register reads; r0 is hardwired to zero
   assign rs_v         = (rs_i  == '0) ? '0 : regs[rs_i];
   assign rt_v         = (rt_i  == '0) ? '0 : regs[rt_i];
   assign bus.dbg_data = (dbg_i == '0) ? '0 : regs[dbg_i];

   // Single-cycle ALU and destination select
   always_comb begin
      alu_v   = '0;
      alu_dst = rd_i;
      illegal = 1'b0;
      is_mul  = 1'b0;
      if (op == OP_RTYPE) begin
         case (fn)
            F_ADD, F_ADDU: alu_v = rs_v + rt_v;
            F_SUB, F_SUBU: alu_v = rs_v - rt_v;
            F_AND:         alu_v = rs_v & rt_v;
            F_OR:          alu_v = rs_v | rt_v;
            F_SLL:         alu_v = rt_v << sh_amt;
            F_SRL:         alu_v = rt_v >> sh_amt;
            F_SLT:         alu_v = XLEN'($signed(rs_v) < $signed(rt_v));
            F_SLTU:        alu_v = XLEN'(rs_v < rt_v);
            F_MUL:         is_mul = 1'b1;
            default:       illegal = 1'b1;
         endcase
      end else begin
         alu_dst = rt_i;
         case (op)
            OP_ADDI, OP_ADDIU: alu_v = rs_v + sext_imm;
            OP_ANDI:           alu_v = rs_v & zext_imm;
            OP_ORI:            alu_v = rs_v | zext_imm;
            OP_SLTI:           alu_v = XLEN'($signed(rs_v) < $signed(sext_imm));
            default:           illegal = 1'b1;
         endcase
      end
      if (illegal) begin
         alu_v   = '0;
         alu_dst = '0;
      end
   end

   // Control FSM: next state, write-back and result selection
   always_comb begin
      state_d    = state_q;
      mul_start  = 1'b0;
      res_fire   = 1'b0;
      res_err_d  = 1'b0;
      res_data_d = '0;
      wr_en      = 1'b0;
      wr_idx     = '0;
      case (state_q)
         IDLE: begin
            if (bus.in_valid && bus.in_ready) begin
               if (is_mul) begin
                  mul_start = 1'b1;
                  state_d   = MUL;
               end else begin
                  res_fire   = 1'b1;
                  res_err_d  = illegal;
                  res_data_d = alu_v;
                  wr_idx     = alu_dst;
                  wr_en      = !illegal;
               end
            end
         end
         MUL: begin
            if (mul_done) begin
               res_fire   = 1'b1;
               res_data_d = mul_product;
               wr_idx     = mul_dst_q;
               wr_en      = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, handshake and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         bus.in_ready  <= 1'b1;
         bus.res_valid <= 1'b0;
         bus.res_data  <= '0;
         bus.res_dst   <= '0;
         bus.res_err   <= 1'b0;
         mul_dst_q     <= '0;
      end else begin
         state_q       <= state_d;
         bus.in_ready  <= (state_d == IDLE);
         bus.res_valid <= res_fire;
         if (res_fire) begin
            bus.res_data <= res_data_d;
            bus.res_dst  <= REG_FW'(wr_idx);
            bus.res_err  <= res_err_d;
         end
         if (mul_start) begin
            mul_dst_q <= alu_dst;
         end
      end
   end

   // Register file; writes to r0 are dropped
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en && (wr_idx != '0)) begin
         regs[wr_idx] <= res_data_d;
      end
   end

   reg_alu_mul #(
      .XLEN(XLEN)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (rs_v),
      .b       (rt_v),
      .done    (mul_done),
      .product (mul_product)
   );

endmodule

// File: tb/tb_reg_alu_core.sv
// tb_reg_alu_core: directed plus random instruction stream against an
// architectural register-file model.
module tb_reg_alu_core;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned NREGS = 32;
   localparam logic [31:0] JUNK  = {6'h08, 5'd0, 5'd20, 16'h0055};

   logic clk;
   logic rst;

   reg_alu_if #(.XLEN(XLEN)) bus ();

   reg_alu_core #(
      .XLEN  (XLEN),
      .NREGS (NREGS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_pass;
   int unsigned n_fail;
   int unsigned n_checks;
   logic [31:0] mregs [32];

   function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] sh);
      return {6'd0, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                         input logic [4:0] rs, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   // Architectural model: executes one instruction on mregs
   function automatic void model(input logic [31:0] i, output logic [31:0] d,
                                 output logic [4:0] dst, output logic err, output logic mul);
      logic [5:0]  op, fn;
      logic [4:0]  rs, rt, rd, sh;
      logic [15:0] imm;
      logic [31:0] a, b, simm, zimm;
      op = i[31:26]; rs = i[25:21]; rt = i[20:16]; rd = i[15:11];
      sh = i[10:6];  fn = i[5:0];   imm = i[15:0];
      a = mregs[rs]; b = mregs[rt];
      simm = {{16{imm[15]}}, imm};
      zimm = {16'd0, imm};
      d = 32'd0; err = 1'b0; mul = 1'b0; dst = rd;
      if (op == 6'd0) begin
         case (fn)
            6'h20, 6'h21: d = a + b;
            6'h22, 6'h23: d = a - b;
            6'h24:        d = a & b;
            6'h25:        d = a | b;
            6'h00:        d = b << sh;
            6'h02:        d = b >> sh;
            6'h2a:        d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h2b:        d = (a < b) ? 32'd1 : 32'd0;
            6'h18:        begin d = a * b; mul = 1'b1; end
            default:      err = 1'b1;
         endcase
      end else begin
         dst = rt;
         case (op)
            6'h08, 6'h09: d = a + simm;
            6'h0c:        d = a & zimm;
            6'h0d:        d = a | zimm;
            6'h0a:        d = ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0;
            default:      err = 1'b1;
         endcase
      end
      if (err) begin
         d   = 32'd0;
         dst = 5'd0;
      end
      if (!err && dst != 5'd0) mregs[dst] = d;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one instruction at a negedge and check its result pulse
   task automatic do_op(input logic [31:0] i, input string tag,
                        input bit use_lit, input logic [31:0] lit);
      logic [31:0] ed;
      logic [4:0]  edst;
      logic        eerr, emul;
      int unsigned k;
      bit          ready_ok;
      model(i, ed, edst, eerr, emul);
      check({tag, " ready"}, 64'(bus.in_ready), 64'(1'b1));
      bus.in_valid = 1'b1;
      bus.instr    = i;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      k = 1;
      ready_ok = 1'b1;
      if (emul) begin
         // busy window: junk requests must be ignored
         while (!bus.res_valid && k < 3 * XLEN) begin
            if (bus.in_ready) ready_ok = 1'b0;
            bus.in_valid = (k < XLEN);
            bus.instr    = JUNK;
            @(negedge clk);
            k++;
         end
         bus.in_valid = 1'b0;
         check({tag, " mul_latency"}, 64'(k), 64'(XLEN + 1));
         check({tag, " busy_ready_low"}, 64'(ready_ok), 64'(1'b1));
         check({tag, " ready_back"}, 64'(bus.in_ready), 64'(1'b1));
      end
      check({tag, " valid"}, 64'(bus.res_valid), 64'(1'b1));
      check({tag, " data"}, 64'(bus.res_data), 64'(ed));
      check({tag, " dst"}, 64'(bus.res_dst), 64'(edst));
      check({tag, " err"}, 64'(bus.res_err), 64'(eerr));
      if (use_lit) check({tag, " literal"}, 64'(bus.res_data), 64'(lit));
   endtask

   task automatic dbg_chk(input logic [4:0] a, input string tag);
      bus.dbg_addr = a;
      #1;
      check(tag, 64'(bus.dbg_data), 64'(mregs[a]));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned pulses;
      int unsigned sel;
      logic [4:0]  ra, rb, rc, sa;
      logic [15:0] im;
      logic [31:0] ins;

      n_pass = 0; n_fail = 0; n_checks = 0;
      for (int r = 0; r < 32; r++) mregs[r] = 32'd0;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.instr    = 32'd0;
      bus.dbg_addr = 5'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      check("rst in_ready", 64'(bus.in_ready), 64'(1'b1));
      check("rst res_valid", 64'(bus.res_valid), 64'(1'b0));
      check("rst res_data", 64'(bus.res_data), 64'(0));
      check("rst res_dst", 64'(bus.res_dst), 64'(0));
      check("rst res_err", 64'(bus.res_err), 64'(1'b0));
      dbg_chk(5'd16, "rst dbg16");

      // back-to-back add chain
      do_op(enc_i(6'h08, 5'd16, 5'd0, 16'd4), "addi16", 1'b1, 32'd4);
      do_op(enc_i(6'h08, 5'd17, 5'd0, 16'd2), "addi17", 1'b1, 32'd2);
      do_op(enc_r(6'h20, 5'd3, 5'd16, 5'd17, 5'd0), "add3", 1'b1, 32'd6);

      // sub and compares
      do_op(enc_r(6'h22, 5'd4, 5'd17, 5'd16, 5'd0), "sub4", 1'b1, 32'hFFFF_FFFE);
      do_op(enc_r(6'h2a, 5'd5, 5'd4, 5'd0, 5'd0), "slt5", 1'b1, 32'd1);
      do_op(enc_r(6'h2b, 5'd13, 5'd4, 5'd0, 5'd0), "sltu13", 1'b1, 32'd0);

      // multiply
      do_op(enc_r(6'h18, 5'd6, 5'd16, 5'd17, 5'd0), "mul6", 1'b1, 32'd8);
      do_op(enc_i(6'h08, 5'd10, 5'd0, 16'hFFFF), "addi10", 1'b1, 32'hFFFF_FFFF);
      do_op(enc_i(6'h08, 5'd11, 5'd0, 16'd3), "addi11", 1'b1, 32'd3);
      do_op(enc_r(6'h18, 5'd12, 5'd10, 5'd11, 5'd0), "mul12", 1'b1, 32'hFFFF_FFFD);
      dbg_chk(5'd20, "junk ignored r20");

      // immediate extension and shifts
      do_op(enc_i(6'h0d, 5'd1, 5'd0, 16'h8000), "ori1", 1'b1, 32'h0000_8000);
      do_op(enc_i(6'h08, 5'd2, 5'd0, 16'h8000), "addi2", 1'b1, 32'hFFFF_8000);
      do_op(enc_r(6'h00, 5'd7, 5'd0, 5'd1, 5'd16), "sll7", 1'b1, 32'h8000_0000);
      do_op(enc_r(6'h02, 5'd8, 5'd0, 5'd7, 5'd31), "srl8", 1'b1, 32'd1);
      do_op(enc_i(6'h0c, 5'd14, 5'd2, 16'hF0F0), "andi14", 1'b1, 32'h0000_8000);
      do_op(enc_i(6'h0a, 5'd15, 5'd2, 16'd1), "slti15", 1'b1, 32'd1);

      // illegal opcode, then write to r0
      do_op(enc_i(6'h3f, 5'd18, 5'd16, 16'h1234), "illegal", 1'b1, 32'd0);
      do_op(enc_r(6'h20, 5'd0, 5'd16, 5'd17, 5'd0), "add_r0", 1'b1, 32'd6);
      dbg_chk(5'd0, "dbg r0");
      for (int r = 0; r < 32; r++) dbg_chk(5'(r), "scan1");

      // reset during multiply
      bus.in_valid = 1'b1;
      bus.instr    = enc_r(6'h18, 5'd9, 5'd16, 5'd17, 5'd0);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      pulses = 0;
      for (int c = 1; c < 10; c++) begin
         if (bus.res_valid) pulses++;
         @(negedge clk);
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int r = 0; r < 32; r++) mregs[r] = 32'd0;
      check("midmul in_ready", 64'(bus.in_ready), 64'(1'b1));
      check("midmul res_valid", 64'(bus.res_valid), 64'(1'b0));
      for (int c = 0; c < 40; c++) begin
         if (bus.res_valid) pulses++;
         @(negedge clk);
      end
      check("midmul no pulse", 64'(pulses), 64'(0));
      dbg_chk(5'd9, "midmul r9");
      dbg_chk(5'd16, "midmul r16");

      // random stream
      for (int n = 0; n < 300; n++) begin
         sel = $urandom_range(0, 19);
         ra  = 5'($urandom_range(0, 31));
         rb  = 5'($urandom_range(0, 31));
         rc  = 5'($urandom_range(0, 31));
         sa  = 5'($urandom_range(0, 31));
         im  = 16'($urandom);
         case (sel)
            0:  ins = enc_r(6'h20, ra, rb, rc, sa);
            1:  ins = enc_r(6'h21, ra, rb, rc, sa);
            2:  ins = enc_r(6'h22, ra, rb, rc, sa);
            3:  ins = enc_r(6'h23, ra, rb, rc, sa);
            4:  ins = enc_r(6'h24, ra, rb, rc, sa);
            5:  ins = enc_r(6'h25, ra, rb, rc, sa);
            6:  ins = enc_r(6'h00, ra, rb, rc, sa);
            7:  ins = enc_r(6'h02, ra, rb, rc, sa);
            8:  ins = enc_r(6'h2a, ra, rb, rc, sa);
            9:  ins = enc_r(6'h2b, ra, rb, rc, sa);
            10: ins = enc_r(6'h18, ra, rb, rc, sa);
            11, 12: ins = enc_i(6'h08, ra, rb, im);
            13: ins = enc_i(6'h09, ra, rb, im);
            14: ins = enc_i(6'h0c, ra, rb, im);
            15: ins = enc_i(6'h0d, ra, rb, im);
            16: ins = enc_i(6'h0a, ra, rb, im);
            17: ins = enc_r(6'h3f, ra, rb, rc, sa);
            18: ins = enc_i(6'h04, ra, rb, im);
            default: ins = enc_i(6'h08, ra, 5'd0, im);
         endcase
         do_op(ins, "rnd", 1'b0, 32'd0);
         if (n % 20 == 0) dbg_chk(5'($urandom_range(0, 31)), "rnd dbg");
      end
      for (int r = 0; r < 32; r++) dbg_chk(5'(r), "scan2");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
